// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and encodings for the multicycle control sequencer.
package multicycle_sequencer_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       ir_en;
    logic       iord;
    logic       leer_mem;
    logic       escr_mem;
    logic       mema_reg;
    logic       reg_dest;
    logic       escr_reg;
    logic       alu_a;
    logic [1:0] alu_b;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;
  } ctrl_t;

  function automatic logic is_mem_wait(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction/memory inputs and datapath control outputs of the sequencer.
interface multicycle_sequencer_if;
  logic [5:0] instruccion;
  logic [5:0] CampoFuncion;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       ir_en;
  logic       IorD;
  logic       LeerMem;
  logic       EscrMem;
  logic       MemaReg;
  logic       RegDest;
  logic       EscrReg;
  logic       FuenteALUA;
  logic [1:0] FuenteALUB;
  logic [1:0] FuentePC;
  logic [2:0] controldeALU;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state_o;

  modport master (
    output instruccion, CampoFuncion, zero, mem_ready,
    input  pc_en, ir_en, IorD, LeerMem, EscrMem, MemaReg, RegDest, EscrReg,
           FuenteALUA, FuenteALUB, FuentePC, controldeALU,
           instr_done, illegal_op, mem_timeout, state_o
  );

  modport slave (
    input  instruccion, CampoFuncion, zero, mem_ready,
    output pc_en, ir_en, IorD, LeerMem, EscrMem, MemaReg, RegDest, EscrReg,
           FuenteALUA, FuenteALUB, FuentePC, controldeALU,
           instr_done, illegal_op, mem_timeout, state_o
  );
endinterface

// File: rtl/multicycle_sequencer_alu_decoder.sv
// Combinational R-type funct decoder: ALU control code plus a valid flag.
module alu_decoder
  import multicycle_sequencer_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       valid_o
);

  always_comb begin
    alu_ctrl_o = ALU_AND;
    valid_o    = 1'b1;
    case (funct_i)
      FN_ADD:  alu_ctrl_o = ALU_ADD;
      FN_SUB:  alu_ctrl_o = ALU_SUB;
      FN_AND:  alu_ctrl_o = ALU_AND;
      FN_OR:   alu_ctrl_o = ALU_OR;
      FN_SLT:  alu_ctrl_o = ALU_SLT;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle datapath control FSM with per-access memory stall timeout.
// Define MULTICYCLE_JUMP_EN to support the j instruction (JUMP state).
//
// state   | meaning
// FETCH   | read instruction, PC+4; waits on mem_ready
// DECODE  | branch target precompute, opcode dispatch
// MEMADR  | lw/sw effective address
// MEMRD   | data read; waits on mem_ready
// MEMWB   | load result to rt
// MEMWR   | data write; waits on mem_ready
// EXEC    | R-type ALU op from funct
// RTYPEWB | ALU result to rd
// BEQ     | compare, conditional PC load from ALUOut
// ADDIEX  | rs + sign-extended immediate
// ADDIWB  | ALU result to rt
// JUMP    | PC load from jump target
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic                   CLK,
  input  logic                   Reset,
  multicycle_sequencer_if.slave  bus
);

  localparam int STALL_W = $clog2(WAIT_MAX + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(WAIT_MAX - 1);

  state_e               state_q, state_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  ctrl_t                ctrl;
  logic [2:0]           exec_alu;
  logic                 exec_valid;
  logic                 stalling;
  logic                 timeout;

  alu_decoder u_alu_decoder (
    .funct_i    (bus.CampoFuncion),
    .alu_ctrl_o (exec_alu),
    .valid_o    (exec_valid)
  );

  // mem_ready in the same cycle as the last allowed stall still completes normally
  assign stalling = is_mem_wait(state_q) && !bus.mem_ready;
  assign timeout  = stalling && (stall_q == STALL_LAST);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_FETCH;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.leer_mem = 1'b1;
        ctrl.alu_b    = SRCB_FOUR;
        ctrl.alu_ctrl = ALU_ADD;
        ctrl.pc_src   = PCSRC_ALU;
        ctrl.ir_en    = bus.mem_ready;
        ctrl.pc_en    = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_b    = SRCB_IMMSH;
        ctrl.alu_ctrl = ALU_ADD;
        case (bus.instruccion)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            state_d         = S_FETCH;
            ctrl.illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_a    = 1'b1;
        ctrl.alu_b    = SRCB_IMM;
        ctrl.alu_ctrl = ALU_ADD;
        state_d       = (bus.instruccion == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.leer_mem = 1'b1;
        if (bus.mem_ready)  state_d = S_MEMWB;
        else if (timeout)   state_d = S_FETCH;
      end
      S_MEMWB: begin
        ctrl.mema_reg   = 1'b1;
        ctrl.escr_reg   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.escr_mem = 1'b1;
        if (bus.mem_ready) begin
          ctrl.instr_done = 1'b1;
          state_d         = S_FETCH;
        end else if (timeout) begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        ctrl.alu_a    = 1'b1;
        ctrl.alu_b    = SRCB_RT;
        ctrl.alu_ctrl = exec_alu;
        if (exec_valid) begin
          state_d = S_RTYPEWB;
        end else begin
          state_d         = S_FETCH;
          ctrl.illegal_op = 1'b1;
        end
      end
      S_RTYPEWB: begin
        ctrl.reg_dest   = 1'b1;
        ctrl.escr_reg   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_BEQ: begin
        ctrl.alu_a      = 1'b1;
        ctrl.alu_b      = SRCB_RT;
        ctrl.alu_ctrl   = ALU_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.pc_en      = bus.zero;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alu_a    = 1'b1;
        ctrl.alu_b    = SRCB_IMM;
        ctrl.alu_ctrl = ALU_ADD;
        state_d       = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.escr_reg   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_en      = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    ctrl.mem_timeout = timeout;

    // Reset blocks every write strobe immediately, even mid-instruction
    if (Reset) begin
      ctrl.pc_en       = 1'b0;
      ctrl.ir_en       = 1'b0;
      ctrl.escr_mem    = 1'b0;
      ctrl.escr_reg    = 1'b0;
      ctrl.instr_done  = 1'b0;
      ctrl.illegal_op  = 1'b0;
      ctrl.mem_timeout = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if ((state_d != state_q) || timeout) stall_d = '0;
    else if (stalling)                   stall_d = stall_q + STALL_W'(1);
  end

  assign bus.pc_en        = ctrl.pc_en;
  assign bus.ir_en        = ctrl.ir_en;
  assign bus.IorD         = ctrl.iord;
  assign bus.LeerMem      = ctrl.leer_mem;
  assign bus.EscrMem      = ctrl.escr_mem;
  assign bus.MemaReg      = ctrl.mema_reg;
  assign bus.RegDest      = ctrl.reg_dest;
  assign bus.EscrReg      = ctrl.escr_reg;
  assign bus.FuenteALUA   = ctrl.alu_a;
  assign bus.FuenteALUB   = ctrl.alu_b;
  assign bus.FuentePC     = ctrl.pc_src;
  assign bus.controldeALU = ctrl.alu_ctrl;
  assign bus.instr_done   = ctrl.instr_done;
  assign bus.illegal_op   = ctrl.illegal_op;
  assign bus.mem_timeout  = ctrl.mem_timeout;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed vector bench for multicycle_sequencer (WAIT_MAX = 15).
module tb_multicycle_sequencer;

  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_MEMADR  = 4'd2;
  localparam logic [3:0] ST_MEMRD   = 4'd3;
  localparam logic [3:0] ST_MEMWB   = 4'd4;
  localparam logic [3:0] ST_MEMWR   = 4'd5;
  localparam logic [3:0] ST_EXEC    = 4'd6;
  localparam logic [3:0] ST_RTYPEWB = 4'd7;
  localparam logic [3:0] ST_BEQ     = 4'd8;
  localparam logic [3:0] ST_ADDIEX  = 4'd9;
  localparam logic [3:0] ST_ADDIWB  = 4'd10;
  localparam logic [3:0] ST_JUMP    = 4'd11;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    logic [18:0] ctrl;
  } vec_t;

  logic CLK = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;
  vec_t vq[$];

  multicycle_sequencer_if bus();

  multicycle_sequencer #(.WAIT_MAX(15)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [18:0] obs;
  assign obs = {bus.pc_en, bus.ir_en, bus.IorD, bus.LeerMem, bus.EscrMem,
                bus.MemaReg, bus.RegDest, bus.EscrReg, bus.FuenteALUA,
                bus.FuenteALUB, bus.FuentePC, bus.controldeALU,
                bus.instr_done, bus.illegal_op, bus.mem_timeout};

  function automatic logic [18:0] cw(input logic pc, ir, iord, lm, em, mr, rd, er, a,
                                     input logic [1:0] b, p, input logic [2:0] alu,
                                     input logic d, il, t);
    return {pc, ir, iord, lm, em, mr, rd, er, a, b, p, alu, d, il, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic v(input logic rst, input logic [5:0] op, fn, input logic z, rdy,
                   input logic [3:0] st, input logic [18:0] c);
    vec_t e;
    e.rst = rst; e.op = op; e.fn = fn; e.z = z; e.rdy = rdy; e.st = st; e.ctrl = c;
    vq.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic [5:0] op, fn, input logic z, rdy);
    Reset = rst; bus.instruccion = op; bus.CampoFuncion = fn; bus.zero = z; bus.mem_ready = rdy;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [18:0] W_FWAIT, W_FETCH, W_DEC, W_DEC_ILL, W_MEMADR, W_MEMRD, W_MEMWB;
  logic [18:0] W_MEMWR, W_MEMWR_RST, W_EXEC_ADD, W_EXEC_SUB, W_EXEC_AND, W_EXEC_OR;
  logic [18:0] W_EXEC_SLT, W_EXEC_BAD, W_RWB, W_BEQ1, W_BEQ0, W_ADDIEX, W_ADDIWB, W_JUMP;

  initial begin
    W_FWAIT     = cw(0,0,0,1,0,0,0,0,0,2'b01,2'b00,3'b010,0,0,0);
    W_FETCH     = cw(1,1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010,0,0,0);
    W_DEC       = cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0,0);
    W_DEC_ILL   = cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,1,0);
    W_MEMADR    = cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0,0);
    W_MEMRD     = cw(0,0,1,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,0,0);
    W_MEMWB     = cw(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,1,0,0);
    W_MEMWR     = cw(0,0,1,0,1,0,0,0,0,2'b00,2'b00,3'b000,1,0,0);
    W_MEMWR_RST = cw(0,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0,0);
    W_EXEC_ADD  = cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0,0,0);
    W_EXEC_SUB  = cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b110,0,0,0);
    W_EXEC_AND  = cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000,0,0,0);
    W_EXEC_OR   = cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b001,0,0,0);
    W_EXEC_SLT  = cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111,0,0,0);
    W_EXEC_BAD  = cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000,0,1,0);
    W_RWB       = cw(0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,1,0,0);
    W_BEQ1      = cw(1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,1,0,0);
    W_BEQ0      = cw(0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,1,0,0);
    W_ADDIEX    = cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0,0);
    W_ADDIWB    = cw(0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,1,0,0);
    W_JUMP      = cw(1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,1,0,0);

    // reset held: FETCH with fetch strobes suppressed
    v(1, 6'h00, 6'h00, 0, 1, ST_FETCH, W_FWAIT);
    // add, sub, and, or, slt
    v(0, 6'b000000, 6'b100000, 0, 1, ST_FETCH, W_FETCH);
    v(0, 6'b000000, 6'b100000, 0, 1, ST_DECODE, W_DEC);
    v(0, 6'b000000, 6'b100000, 0, 1, ST_EXEC, W_EXEC_ADD);
    v(0, 6'b000000, 6'b100000, 0, 1, ST_RTYPEWB, W_RWB);
    v(0, 6'b000000, 6'b100010, 0, 1, ST_FETCH, W_FETCH);
    v(0, 6'b000000, 6'b100010, 0, 1, ST_DECODE, W_DEC);
    v(0, 6'b000000, 6'b100010, 0, 1, ST_EXEC, W_EXEC_SUB);
    v(0, 6'b000000, 6'b100010, 0, 1, ST_RTYPEWB, W_RWB);
    v(0, 6'b000000, 6'b100100, 0, 1, ST_FETCH, W_FETCH);
    v(0, 6'b000000, 6'b100100, 0, 1, ST_DECODE, W_DEC);
    v(0, 6'b000000, 6'b100100, 0, 1, ST_EXEC, W_EXEC_AND);
    v(0, 6'b000000, 6'b100100, 0, 1, ST_RTYPEWB, W_RWB);
    v(0, 6'b000000, 6'b100101, 0, 1, ST_FETCH, W_FETCH);
    v(0, 6'b000000, 6'b100101, 0, 1, ST_DECODE, W_DEC);
    v(0, 6'b000000, 6'b100101, 0, 1, ST_EXEC, W_EXEC_OR);
    v(0, 6'b000000, 6'b100101, 0, 1, ST_RTYPEWB, W_RWB);
    v(0, 6'b000000, 6'b101010, 0, 1, ST_FETCH, W_FETCH);
    v(0, 6'b000000, 6'b101010, 0, 1, ST_DECODE, W_DEC);
    v(0, 6'b000000, 6'b101010, 0, 1, ST_EXEC, W_EXEC_SLT);
    v(0, 6'b000000, 6'b101010, 0, 1, ST_RTYPEWB, W_RWB);
    // unsupported funct
    v(0, 6'b000000, 6'b100001, 0, 1, ST_FETCH, W_FETCH);
    v(0, 6'b000000, 6'b100001, 0, 1, ST_DECODE, W_DEC);
    v(0, 6'b000000, 6'b100001, 0, 1, ST_EXEC, W_EXEC_BAD);
    // lw, no stalls (5 cycles)
    v(0, 6'b100011, 6'h00, 0, 1, ST_FETCH, W_FETCH);
    v(0, 6'b100011, 6'h00, 0, 1, ST_DECODE, W_DEC);
    v(0, 6'b100011, 6'h00, 0, 1, ST_MEMADR, W_MEMADR);
    v(0, 6'b100011, 6'h00, 0, 1, ST_MEMRD, W_MEMRD);
    v(0, 6'b100011, 6'h00, 0, 1, ST_MEMWB, W_MEMWB);
    // sw (4 cycles)
    v(0, 6'b101011, 6'h00, 0, 1, ST_FETCH, W_FETCH);
    v(0, 6'b101011, 6'h00, 0, 1, ST_DECODE, W_DEC);
    v(0, 6'b101011, 6'h00, 0, 1, ST_MEMADR, W_MEMADR);
    v(0, 6'b101011, 6'h00, 0, 1, ST_MEMWR, W_MEMWR);
    // addi
    v(0, 6'b001000, 6'h00, 0, 1, ST_FETCH, W_FETCH);
    v(0, 6'b001000, 6'h00, 0, 1, ST_DECODE, W_DEC);
    v(0, 6'b001000, 6'h00, 0, 1, ST_ADDIEX, W_ADDIEX);
    v(0, 6'b001000, 6'h00, 0, 1, ST_ADDIWB, W_ADDIWB);
    // beq taken / not taken
    v(0, 6'b000100, 6'h00, 1, 1, ST_FETCH, W_FETCH);
    v(0, 6'b000100, 6'h00, 1, 1, ST_DECODE, W_DEC);
    v(0, 6'b000100, 6'h00, 1, 1, ST_BEQ, W_BEQ1);
    v(0, 6'b000100, 6'h00, 0, 1, ST_FETCH, W_FETCH);
    v(0, 6'b000100, 6'h00, 0, 1, ST_DECODE, W_DEC);
    v(0, 6'b000100, 6'h00, 0, 1, ST_BEQ, W_BEQ0);
    // unknown opcode
    v(0, 6'b111111, 6'h00, 0, 1, ST_FETCH, W_FETCH);
    v(0, 6'b111111, 6'h00, 0, 1, ST_DECODE, W_DEC_ILL);
    // jump
    v(0, 6'b000010, 6'h00, 0, 1, ST_FETCH, W_FETCH);
`ifdef MULTICYCLE_JUMP_EN
    v(0, 6'b000010, 6'h00, 0, 1, ST_DECODE, W_DEC);
    v(0, 6'b000010, 6'h00, 0, 1, ST_JUMP, W_JUMP);
`else
    v(0, 6'b000010, 6'h00, 0, 1, ST_DECODE, W_DEC_ILL);
`endif
    // reset asserted in MEMWR with mem_ready high
    v(0, 6'b101011, 6'h00, 0, 1, ST_FETCH, W_FETCH);
    v(0, 6'b101011, 6'h00, 0, 1, ST_DECODE, W_DEC);
    v(0, 6'b101011, 6'h00, 0, 1, ST_MEMADR, W_MEMADR);
    v(1, 6'b101011, 6'h00, 0, 1, ST_MEMWR, W_MEMWR_RST);
    // lw with 3 stall cycles in MEMRD (8 cycles total)
    v(0, 6'b100011, 6'h00, 0, 1, ST_FETCH, W_FETCH);
    v(0, 6'b100011, 6'h00, 0, 1, ST_DECODE, W_DEC);
    v(0, 6'b100011, 6'h00, 0, 1, ST_MEMADR, W_MEMADR);
    v(0, 6'b100011, 6'h00, 0, 0, ST_MEMRD, W_MEMRD);
    v(0, 6'b100011, 6'h00, 0, 0, ST_MEMRD, W_MEMRD);
    v(0, 6'b100011, 6'h00, 0, 0, ST_MEMRD, W_MEMRD);
    v(0, 6'b100011, 6'h00, 0, 1, ST_MEMRD, W_MEMRD);
    v(0, 6'b100011, 6'h00, 0, 1, ST_MEMWB, W_MEMWB);

    drive(1, 6'h00, 6'h00, 0, 0);
    tick();
    tick();

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].op, vq[i].fn, vq[i].z, vq[i].rdy);
      @(negedge CLK);
      chk($sformatf("vec%0d_state", i), 32'(bus.state_o), 32'(vq[i].st));
      chk($sformatf("vec%0d_ctrl", i), 32'(obs), 32'(vq[i].ctrl));
      tick();
    end

    // FETCH stall: timeout on the 15th stall cycle, fetch strobes never issued
    for (int i = 1; i <= 15; i++) begin
      drive(0, 6'h00, 6'h00, 0, 0);
      @(negedge CLK);
      chk($sformatf("fstall%0d_state", i), 32'(bus.state_o), 32'(ST_FETCH));
      chk($sformatf("fstall%0d_ctrl", i), 32'(obs),
          32'(W_FWAIT | ((i == 15) ? 19'd1 : 19'd0)));
      tick();
    end
    // counter restarts: 14 more stalls, then ready on the would-be timeout cycle
    for (int i = 1; i <= 14; i++) begin
      drive(0, 6'h00, 6'h00, 0, 0);
      @(negedge CLK);
      chk($sformatf("fre%0d_ctrl", i), 32'(obs), 32'(W_FWAIT));
      tick();
    end
    drive(0, 6'b111111, 6'h00, 0, 1);
    @(negedge CLK);
    chk("ready_wins_ctrl", 32'(obs), 32'(W_FETCH));
    tick();
    @(negedge CLK);
    chk("ready_wins_state", 32'(bus.state_o), 32'(ST_DECODE));
    tick();

    // MEMRD stall timeout: back to FETCH without a register write
    drive(0, 6'b100011, 6'h00, 0, 1);
    tick();
    tick();
    @(negedge CLK);
    chk("rdto_memadr", 32'(bus.state_o), 32'(ST_MEMADR));
    tick();
    for (int i = 1; i <= 15; i++) begin
      drive(0, 6'b100011, 6'h00, 0, 0);
      @(negedge CLK);
      chk($sformatf("rdto%0d_state", i), 32'(bus.state_o), 32'(ST_MEMRD));
      chk($sformatf("rdto%0d_ctrl", i), 32'(obs),
          32'(W_MEMRD | ((i == 15) ? 19'd1 : 19'd0)));
      tick();
    end
    drive(0, 6'b100011, 6'h00, 0, 0);
    @(negedge CLK);
    chk("rdto_back_fetch", 32'(bus.state_o), 32'(ST_FETCH));
    chk("rdto_no_write", 32'(bus.EscrReg), 32'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
